// File: rtl/bram1be_arbiter.sv
// -----------------------------------------------------------------------------
// bram1be_arbiter
//   Two requesters (A, B) share one single-ported, byte-enable BRAM.
//   Round-robin arbitration issues at most one access per cycle. Read data is
//   captured from the BRAM after its fixed latency and queued in a per-port
//   4-deep response FIFO, in issue order. Writes produce no response.
//
// Ports
//   CLK, RST_N                  clock, asynchronous active-low reset
//   {A,B}_REQ_VALID/READY       request handshake (READY = grant, combinational)
//   {A,B}_REQ_WE/ADDR/DATA      lane write enables (all-zero = read), address, data
//   {A,B}_RSP_VALID/READY/DATA  read-response handshake and data
//   BRAM_EN/WE/ADDR/DI          issued access towards the BRAM
//   BRAM_DO                     BRAM read data
// -----------------------------------------------------------------------------
module bram1be_arbiter #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int CHUNKSIZE  = 8,
  parameter int WE_WIDTH   = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,

  input  logic                  A_REQ_VALID,
  output logic                  A_REQ_READY,
  input  logic [WE_WIDTH-1:0]   A_REQ_WE,
  input  logic [ADDR_WIDTH-1:0] A_REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] A_REQ_DATA,
  output logic                  A_RSP_VALID,
  input  logic                  A_RSP_READY,
  output logic [DATA_WIDTH-1:0] A_RSP_DATA,

  input  logic                  B_REQ_VALID,
  output logic                  B_REQ_READY,
  input  logic [WE_WIDTH-1:0]   B_REQ_WE,
  input  logic [ADDR_WIDTH-1:0] B_REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] B_REQ_DATA,
  output logic                  B_RSP_VALID,
  input  logic                  B_RSP_READY,
  output logic [DATA_WIDTH-1:0] B_RSP_DATA,

  output logic                  BRAM_EN,
  output logic [WE_WIDTH-1:0]   BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int L     = 1 + PIPELINED;  // BRAM read latency in cycles
  localparam int DEPTH = 4;              // response FIFO depth == read credit limit

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  if (DATA_WIDTH != CHUNKSIZE * WE_WIDTH) begin : g_bad_cfg
    $error("bram1be_arbiter: DATA_WIDTH must equal CHUNKSIZE*WE_WIDTH");
  end

  // Per-port views so the two ports share one description.
  logic                  w_req_valid [2];
  logic [WE_WIDTH-1:0]   w_req_we    [2];
  logic [ADDR_WIDTH-1:0] w_req_addr  [2];
  logic [DATA_WIDTH-1:0] w_req_data  [2];
  logic                  w_rsp_ready [2];
  logic                  w_elig      [2];
  logic                  w_grant     [2];
  logic                  w_push      [2];
  logic                  w_pop       [2];
  logic [2:0]            w_inflight  [2];

  assign w_req_valid[0] = A_REQ_VALID;  assign w_req_valid[1] = B_REQ_VALID;
  assign w_req_we[0]    = A_REQ_WE;     assign w_req_we[1]    = B_REQ_WE;
  assign w_req_addr[0]  = A_REQ_ADDR;   assign w_req_addr[1]  = B_REQ_ADDR;
  assign w_req_data[0]  = A_REQ_DATA;   assign w_req_data[1]  = B_REQ_DATA;
  assign w_rsp_ready[0] = A_RSP_READY;  assign w_rsp_ready[1] = B_RSP_READY;

  // Read-tracking shift register: {valid, port} per issue slot.
  logic [L-1:0]          r_pipe_v;
  logic [L-1:0]          r_pipe_p;
  port_e                 r_prio;

  // Response FIFO state.
  logic [DATA_WIDTH-1:0] r_fifo_mem [2][DEPTH];
  logic [1:0]            r_wr_ptr   [2];
  logic [1:0]            r_rd_ptr   [2];
  logic [2:0]            r_cnt      [2];

  // NOTE: every variable assigned in always_comb gets a default before any
  // conditional update, so no path can leave it unassigned (no latch).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_inflight[p] = '0;
      for (int s = 0; s < L; s++) begin
        if (r_pipe_v[s] && (r_pipe_p[s] == 1'(p))) begin
          w_inflight[p] = w_inflight[p] + 3'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    logic       w_is_rd;
    logic [2:0] w_credit;

    assign w_is_rd  = ~|w_req_we[g];
    // Credit counts reads already owed to this port (queued or in the BRAM);
    // capping it at DEPTH makes FIFO overflow impossible.
    assign w_credit = r_cnt[g] + w_inflight[g];
    // RST_N gating keeps grants (and hence BRAM_EN) low throughout reset.
    assign w_elig[g] = RST_N && w_req_valid[g] && (!w_is_rd || (w_credit < 3'(DEPTH)));
    assign w_push[g] = r_pipe_v[L-1] && (r_pipe_p[L-1] == 1'(g));
    assign w_pop[g]  = (r_cnt[g] != 3'd0) && w_rsp_ready[g];

    // NOTE: state registers use non-blocking assignments and the asynchronous
    // active-low reset, so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_wr_ptr[g] <= '0;
        r_rd_ptr[g] <= '0;
        r_cnt[g]    <= '0;
      end else begin
        if (w_push[g]) r_wr_ptr[g] <= r_wr_ptr[g] + 2'd1;
        if (w_pop[g])  r_rd_ptr[g] <= r_rd_ptr[g] + 2'd1;
        case ({w_push[g], w_pop[g]})
          2'b10:   r_cnt[g] <= r_cnt[g] + 3'd1;
          2'b01:   r_cnt[g] <= r_cnt[g] - 3'd1;
          default: r_cnt[g] <= r_cnt[g];
        endcase
      end
    end

    // NOTE: FIFO storage is deliberately not reset; the reset pointers and
    // count make stale contents unobservable.
    always_ff @(posedge CLK) begin
      if (w_push[g]) r_fifo_mem[g][r_wr_ptr[g]] <= BRAM_DO;
    end

    assert property (@(posedge CLK) disable iff (!RST_N)
                     w_push[g] |-> (r_cnt[g] != 3'(DEPTH)))
      else $error("bram1be_arbiter: response FIFO %0d pushed while full", g);
  end

  // Round-robin grant: a lone eligible port wins; on contention the priority
  // pointer decides.
  logic w_any;
  logic w_win;
  logic w_issue_rd;

  assign w_grant[0] = w_elig[0] && (!w_elig[1] || (r_prio == PORT_A));
  assign w_grant[1] = w_elig[1] && (!w_elig[0] || (r_prio == PORT_B));
  assign w_any      = w_grant[0] || w_grant[1];
  assign w_win      = w_grant[1];
  assign w_issue_rd = w_any && ~|w_req_we[w_win];

  assign BRAM_EN   = w_any;
  assign BRAM_WE   = w_any ? w_req_we[w_win] : '0;
  assign BRAM_ADDR = w_req_addr[w_win];
  assign BRAM_DI   = w_req_data[w_win];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_prio   <= PORT_A;
      r_pipe_v <= '0;
      r_pipe_p <= '0;
    end else begin
      if (w_any) r_prio <= port_e'(~w_win);
      r_pipe_v[0] <= w_issue_rd;
      r_pipe_p[0] <= w_win;
      for (int s = L - 1; s > 0; s--) begin
        r_pipe_v[s] <= r_pipe_v[s-1];
        r_pipe_p[s] <= r_pipe_p[s-1];
      end
    end
  end

  assign A_REQ_READY = w_grant[0];
  assign B_REQ_READY = w_grant[1];
  assign A_RSP_VALID = (r_cnt[0] != 3'd0);
  assign B_RSP_VALID = (r_cnt[1] != 3'd0);
  assign A_RSP_DATA  = r_fifo_mem[0][r_rd_ptr[0]];
  assign B_RSP_DATA  = r_fifo_mem[1][r_rd_ptr[1]];

endmodule

// File: tb/tb_bram1be_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram1be_arbiter
//   Scoreboard bench for bram1be_arbiter. Per-port drivers take requests from
//   queues; a request monitor checks each cycle's grants against a round-robin
//   and credit model and, on acceptance, applies writes to a reference memory
//   or pushes the expected read data; a response monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_bram1be_arbiter;

  localparam int PIPELINED = 1;
  localparam int AW = 4;
  localparam int CS = 8;
  localparam int WW = 4;
  localparam int DW = CS * WW;
  localparam int L  = 1 + PIPELINED;

  typedef struct {
    logic [WW-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
  } req_t;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          req_valid [2];
  logic          req_ready [2];
  logic [WW-1:0] req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] req_data  [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [DW-1:0] rsp_data  [2];
  logic          BRAM_EN;
  logic [WW-1:0] BRAM_WE;
  logic [AW-1:0] BRAM_ADDR;
  logic [DW-1:0] BRAM_DI;
  logic [DW-1:0] BRAM_DO;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  req_t          req_q [2][$];
  logic [DW-1:0] exp_q [2][$];
  logic [DW-1:0] ref_mem [16];
  int            acc_rd [2]       = '{0, 0};
  int            pop_cnt [2]      = '{0, 0};
  int            n_rd_acc [2]     = '{0, 0};
  int            n_wr_acc [2]     = '{0, 0};
  int            n_rsp [2]        = '{0, 0};
  int            last_rd_issue [2] = '{0, 0};
  logic [DW-1:0] last_rsp [2];
  logic          busy [2];
  int            rdy_mode [2]     = '{1, 1};  // 0 low, 1 high, 2 random
  int            prio = 0;

  bram1be_arbiter #(
    .PIPELINED(PIPELINED), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .CHUNKSIZE(CS), .WE_WIDTH(WW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .A_REQ_VALID(req_valid[0]), .A_REQ_READY(req_ready[0]), .A_REQ_WE(req_we[0]),
    .A_REQ_ADDR(req_addr[0]), .A_REQ_DATA(req_data[0]),
    .A_RSP_VALID(rsp_valid[0]), .A_RSP_READY(rsp_ready[0]), .A_RSP_DATA(rsp_data[0]),
    .B_REQ_VALID(req_valid[1]), .B_REQ_READY(req_ready[1]), .B_REQ_WE(req_we[1]),
    .B_REQ_ADDR(req_addr[1]), .B_REQ_DATA(req_data[1]),
    .B_RSP_VALID(rsp_valid[1]), .B_RSP_READY(rsp_ready[1]), .B_RSP_DATA(rsp_data[1]),
    .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE), .BRAM_ADDR(BRAM_ADDR),
    .BRAM_DI(BRAM_DI), .BRAM_DO(BRAM_DO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural byte-enable BRAM with read latency L.
  logic [DW-1:0] bram_mem [16];
  logic [DW-1:0] do_q1, do_q2;
  initial for (int i = 0; i < 16; i++) bram_mem[i] = '0;
  always @(posedge CLK) begin
    if (BRAM_EN) begin
      for (int i = 0; i < WW; i++)
        if (BRAM_WE[i]) bram_mem[BRAM_ADDR][CS*i +: CS] <= BRAM_DI[CS*i +: CS];
      do_q1 <= bram_mem[BRAM_ADDR];
    end
    do_q2 <= do_q1;
  end
  assign BRAM_DO = (PIPELINED != 0) ? do_q2 : do_q1;

  // Response-ready generator.
  initial begin
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    forever begin
      @(posedge CLK); #1;
      for (int p = 0; p < 2; p++)
        rsp_ready[p] = (rdy_mode[p] == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode[p] == 1);
    end
  end

  // Request drivers: fields held stable until the grant is seen.
  for (genvar g = 0; g < 2; g++) begin : g_drv
    initial begin
      req_t r;
      int   k;
      req_valid[g] = 1'b0; req_we[g] = '0; req_addr[g] = '0; req_data[g] = '0;
      busy[g] = 1'b0;
      forever begin
        if (req_q[g].size() == 0) begin
          busy[g] = 1'b0;
          req_valid[g] = 1'b0;
          @(posedge CLK); #1;
        end else begin
          r = req_q[g].pop_front();
          busy[g] = 1'b1;
          repeat (r.gap) begin req_valid[g] = 1'b0; @(posedge CLK); #1; end
          req_we[g] = r.we; req_addr[g] = r.addr; req_data[g] = r.data;
          req_valid[g] = 1'b1;
          k = 0;
          do begin @(negedge CLK); k++; end while (req_ready[g] !== 1'b1 && k < 400);
          if (req_ready[g] !== 1'b1) check($sformatf("req_timeout_%0d", g), 0, 1);
          @(posedge CLK); #1;
          req_valid[g] = 1'b0;
        end
      end
    end
  end

  // Request monitor: grant model and scoreboard producer.
  always @(negedge CLK) begin
    logic elig [2];
    logic exp_g [2];
    if (!RST_N) begin
      prio = 0;
      for (int p = 0; p < 2; p++) begin
        exp_q[p].delete();
        acc_rd[p] = pop_cnt[p];
        check($sformatf("ready_in_reset_%0d", p), req_ready[p], 0);
      end
    end else begin
      for (int p = 0; p < 2; p++)
        elig[p] = req_valid[p] && ((req_we[p] != 0) || ((acc_rd[p] - pop_cnt[p]) < 4));
      exp_g[0] = elig[0] && (!elig[1] || prio == 0);
      exp_g[1] = elig[1] && (!elig[0] || prio == 1);
      for (int p = 0; p < 2; p++) begin
        check($sformatf("grant_%0d", p), req_ready[p], exp_g[p]);
        if (exp_g[p]) begin
          if (req_we[p] != 0) begin
            for (int i = 0; i < WW; i++)
              if (req_we[p][i]) ref_mem[req_addr[p]][CS*i +: CS] = req_data[p][CS*i +: CS];
            n_wr_acc[p]++;
          end else begin
            exp_q[p].push_back(ref_mem[req_addr[p]]);
            acc_rd[p]++;
            n_rd_acc[p]++;
            last_rd_issue[p] = cyc;
          end
          prio = 1 - p;
        end
      end
    end
  end

  // Response monitor: scoreboard consumer.
  always @(negedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      if (rsp_valid[p] === 1'b1 && rsp_ready[p]) begin
        if (!RST_N) begin
          check($sformatf("rsp_in_reset_%0d", p), 1, 0);
        end else if (exp_q[p].size() == 0) begin
          check($sformatf("rsp_unexpected_%0d", p), 1, 0);
        end else begin
          check($sformatf("rsp_data_%0d", p), rsp_data[p], exp_q[p].pop_front());
          last_rsp[p] = rsp_data[p];
          n_rsp[p]++;
          pop_cnt[p] <= pop_cnt[p] + 1;
        end
      end
    end
  end

  task automatic push(input int p, input logic [WW-1:0] we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input int gap);
    req_t r;
    r.we = we; r.addr = addr; r.data = data; r.gap = gap;
    req_q[p].push_back(r);
  endtask

  task automatic drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge CLK);
      if (req_q[0].size() == 0 && req_q[1].size() == 0 && !busy[0] && !busy[1] &&
          exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
    end
    if (k >= budget) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int b0, b1, r0, k;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_rsp_valid_a", rsp_valid[0], 0);
    check("rst_rsp_valid_b", rsp_valid[1], 0);
    check("rst_bram_en", BRAM_EN, 0);
    @(posedge CLK); #1 RST_N = 1'b1;
    @(negedge CLK);

    // 1: write then read on A, response latency.
    push(0, 4'hF, 4'd3, 32'h0000005A, 0);
    push(0, 4'h0, 4'd3, 32'h0, 0);
    for (k = 0; k < 50; k++) begin @(negedge CLK); if (rsp_valid[0]) break; end
    check("t1_latency", cyc - last_rd_issue[0], L + 1);
    check("t1_data", rsp_data[0], 32'h0000005A);
    drain(200);

    // 2: both ports streaming reads.
    for (int i = 0; i < 8; i++) begin
      push(0, 4'h0, 4'(i), 32'h0, 0);
      push(1, 4'h0, 4'(i + 8), 32'h0, 0);
    end
    drain(300);

    // 3: byte lanes.
    push(0, 4'hF, 4'd0, 32'h11223344, 0);
    push(0, 4'b0010, 4'd0, 32'hDEADAABE, 0);
    push(0, 4'h0, 4'd0, 32'h0, 0);
    drain(200);
    check("t3_lanes", last_rsp[0], 32'h1122AA44);

    // 4: back-pressure on A, B writes continue.
    rdy_mode[0] = 0;
    b0 = n_rd_acc[0]; b1 = n_wr_acc[1]; r0 = n_rsp[0];
    for (int i = 0; i < 6; i++) push(0, 4'h0, 4'(i), 32'h0, 0);
    for (int i = 0; i < 4; i++) push(1, 4'hF, 4'(12 + i), $urandom, 0);
    repeat (20) @(negedge CLK);
    check("t4_a_accepted", n_rd_acc[0] - b0, 4);
    check("t4_a_stalled", req_ready[0], 0);
    check("t4_b_writes", n_wr_acc[1] - b1, 4);
    rdy_mode[0] = 1;
    drain(300);
    check("t4_a_all", n_rd_acc[0] - b0, 6);
    check("t4_a_rsp", n_rsp[0] - r0, 6);

    // 5: read is not disturbed by the following write.
    push(0, 4'hF, 4'd7, 32'h00000001, 0);
    push(0, 4'h0, 4'd7, 32'h0, 0);
    push(0, 4'hF, 4'd7, 32'h00000002, 0);
    drain(200);
    check("t5_order", last_rsp[0], 32'h00000001);

    // 6: reset with reads in flight.
    b0 = n_rd_acc[0];
    push(0, 4'h0, 4'd1, 32'h0, 0);
    push(0, 4'h0, 4'd2, 32'h0, 0);
    for (k = 0; k < 50; k++) begin @(negedge CLK); if (n_rd_acc[0] - b0 >= 2) break; end
    @(posedge CLK); #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1 RST_N = 1'b1;
    repeat (6) begin
      @(negedge CLK);
      check("t6_no_rsp_a", rsp_valid[0], 0);
    end
    push(0, 4'h0, 4'd5, 32'h0, 0);
    push(1, 4'h0, 4'd6, 32'h0, 0);
    @(negedge CLK);
    check("t6_a_first", req_ready[0], 1);
    check("t6_b_waits", req_ready[1], 0);
    drain(200);

    // Random traffic with random response back-pressure.
    rdy_mode[0] = 2; rdy_mode[1] = 2;
    for (int i = 0; i < 150; i++) begin
      for (int p = 0; p < 2; p++) begin
        push(p, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
             4'($urandom_range(0, 15)), $urandom,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    end
    drain(5000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
